mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Multi-channel memory arbiter for the next-generation system top: merges NUM_CH requester ports
//  (ch0 = dmem, ch1 = imem in the default build) onto one shared memory port using the ren/wen/hit
//  handshake of datapath_if. Holds a grant until the memory answers with hit; adds selectable
//  priority and a wait-timeout watchdog.
// PARAMETERS
//  NUM_CH     2    number of requester channels (>=2)
//  ARB_MODE   0    0 = fixed priority (lowest index wins); 1 = round-robin
//  WAIT_LIMIT 255  max GRANT cycles without mem_hit before abort; 0 disables the watchdog
// PORTS
//  clk        in   1                    system clock
//  nrst       in   1                    async active-low reset
//  req_ren    in   NUM_CH               per-channel read request
//  req_wen    in   NUM_CH               per-channel write request
//  req_addr   in   NUM_CH x word_t      per-channel address
//  req_store  in   NUM_CH x word_t      per-channel write data
//  req_width  in   NUM_CH x LDST_WIDTH_W per-channel access width
//  req_load   out  word_t               read data, broadcast to all channels
//  req_hit    out  NUM_CH               per-channel completion, one-hot or zero
//  mem_ren    out  1                    shared port read enable
//  mem_wen    out  1                    shared port write enable
//  mem_addr   out  word_t               shared port address
//  mem_store  out  word_t               shared port write data
//  mem_width  out  LDST_WIDTH_W         shared port width
//  mem_load   in   word_t               shared port read data
//  mem_hit    in   1                    shared port completion
//  grant      out  $clog2(NUM_CH)       granted channel; valid only while busy=1
//  busy       out  1                    1 in GRANT
//  timeout    out  1                    one-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset: state IDLE, grant=0, rr pointer=0, wait count=0. All outputs 0, req_load=0.
//  - Channel k requests when req_ren[k]|req_wen[k]. Requester holds addr/store/width/en stable
//    until req_hit[k].
//  - IDLE: mem_* outputs 0, req_hit=0. If any request, register winner into grant, go GRANT.
//    No request: stay IDLE.
//  - Fixed mode: lowest requesting index wins.
//  - RR mode: first requester at or after rr pointer, modulo NUM_CH.
//  - GRANT: mem_* driven combinationally from channel grant; req_load = mem_load in all states.
//    - Both ren and wen asserted on the granted channel: wen wins, mem_ren forced 0.
//  - GRANT, mem_hit=1: req_hit[grant]=1 in the same cycle. Next state IDLE. RR pointer <= grant+1
//    (wraps NUM_CH-1 -> 0).
//  - Minimum latency: request seen cycle N, grant cycle N+1, earliest hit N+1.
//    Back-to-back transactions therefore have a 1-cycle IDLE gap.
//  - mem_hit in IDLE is ignored: no req_hit, no state change.
//  - Granted channel drops its request before hit (abandon, e.g. flush): mem_* go 0 that cycle.
//    Next state IDLE, no req_hit. RR pointer advances.
//  - Watchdog (WAIT_LIMIT>0): wait count clears on entering GRANT and increments each GRANT cycle
//    without hit.
//    - Abort when count==WAIT_LIMIT and no hit: timeout=1 for that cycle, next IDLE, no req_hit.
//    - Hit on the limit cycle wins over timeout.
//  - Requests on non-granted channels are held off (req_hit=0) until re-arbitrated.
//  - Async reset mid-GRANT: immediate return to IDLE with all outputs 0. No hit is generated.
// STRUCTURE
//  - rv32ima_pkg additions:
//    - arb_state_t enum {ARB_IDLE, ARB_GRANT}.
//    - arb_mode_t enum {ARB_FIXED, ARB_RR}.
//  - word_t and LDST_WIDTH_W are reused from rv32ima_pkg.
//  - One sub-module, arb_picker: combinational; inputs are the request vector, rr pointer and mode.
//    Outputs are the winner index and an any-request flag.
//  - FSM, wait counter and output muxing stay in mem_arbiter.
// TESTING
//  1. Reset mid-GRANT: ch1 granted, nrst low -> all outputs 0 asynchronously; IDLE after release,
//     no hit.
//  2. Fixed mode: ch0 read 0x100 and ch1 read 0x200 in the same cycle, mem_hit after 2 cycles
//     -> ch0 served first, req_hit[0]; then ch1, req_hit[1]; mem_load 0xDEADBEEF seen at req_load.
//  3. RR mode: ch0 and ch1 both request continuously, hit every GRANT cycle -> grants alternate
//     0,1,0,1 with one IDLE cycle between each.
//  4. Write path: ch0 wen=1, addr 0x40, store 0x12345678, width word -> mem_wen=1, mem_ren=0,
//     exact fields passed through.
//     Then ren=wen=1 on ch0 -> mem_wen=1, mem_ren=0.
//  5. Watchdog: WAIT_LIMIT=4, no mem_hit -> timeout pulses exactly on the 5th GRANT cycle, IDLE
//     next, req_hit never set. Repeat with hit on the 5th cycle -> req_hit, no timeout.
//  6. Abandon: ch1 granted, req_ren[1] dropped before hit -> mem_ren=0 that cycle; next cycle IDLE;
//     a pending ch0 request is granted the cycle after.

Source files
------------

// File: rtl/rv32ima_pkg.sv
// rtl/rv32ima_pkg.sv - shared core types plus memory arbiter state and mode enums
package rv32ima_pkg;

    localparam int XLEN         = 32;
    localparam int LDST_WIDTH_W = 2;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    // Round-robin successor of channel g among n channels.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// rtl/arb_picker.sv - combinational winner selection, fixed priority or round-robin from a pointer
module arb_picker
    import rv32ima_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   rr_ptr_i,
    input  arb_mode_t         mode_i,
    output logic [CH_W-1:0]   win_o,
    output logic              any_o
);

    int   idx;
    logic found;

    always_comb begin
        win_o = '0;
        any_o = |req_i;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (mode_i == ARB_RR) ? (int'(rr_ptr_i) + i) % NUM_CH : i;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win_o = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - merges NUM_CH requesters onto one ren/wen/hit memory port
// Grant is held until mem_hit, abandon by the requester, or a watchdog abort.
module mem_arbiter
    import rv32ima_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ARB_MODE   = 0,
    parameter int WAIT_LIMIT = 255,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic [NUM_CH-1:0]                req_ren,
    input  logic [NUM_CH-1:0]                req_wen,
    input  logic [NUM_CH*XLEN-1:0]           req_addr,
    input  logic [NUM_CH*XLEN-1:0]           req_store,
    input  logic [NUM_CH*LDST_WIDTH_W-1:0]   req_width,
    output logic [XLEN-1:0]                  req_load,
    output logic [NUM_CH-1:0]                req_hit,
    output logic                             mem_ren,
    output logic                             mem_wen,
    output logic [XLEN-1:0]                  mem_addr,
    output logic [XLEN-1:0]                  mem_store,
    output logic [LDST_WIDTH_W-1:0]          mem_width,
    input  logic [XLEN-1:0]                  mem_load,
    input  logic                             mem_hit,
    output logic [CH_W-1:0]                  grant,
    output logic                             busy,
    output logic                             timeout
);

    localparam int        WC_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam arb_mode_t MODE = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

    arb_state_t        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;

    logic [NUM_CH-1:0] req_vec;
    logic [CH_W-1:0]   win;
    logic              any_req;
    logic              in_grant;
    logic              g_ren, g_wen, g_act;
    word_t             g_addr, g_store;
    logic [LDST_WIDTH_W-1:0] g_width;
    logic              wd_limit;
    logic              done;

    assign req_vec  = req_ren | req_wen;
    assign in_grant = (state_q == ARB_GRANT);

    arb_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .req_i    (req_vec),
        .rr_ptr_i (rr_q),
        .mode_i   (MODE),
        .win_o    (win),
        .any_o    (any_req)
    );

    always_comb begin
        g_ren   = req_ren[grant_q];
        g_wen   = req_wen[grant_q];
        g_act   = g_ren | g_wen;
        g_addr  = req_addr[int'(grant_q)*XLEN +: XLEN];
        g_store = req_store[int'(grant_q)*XLEN +: XLEN];
        g_width = req_width[int'(grant_q)*LDST_WIDTH_W +: LDST_WIDTH_W];
    end

    // A hit on the limit cycle takes precedence; an abandoned grant never times out.
    assign wd_limit = (WAIT_LIMIT != 0) && (wcnt_q == WC_W'(WAIT_LIMIT));
    assign timeout  = in_grant & g_act & ~mem_hit & wd_limit;
    assign done     = in_grant & (~g_act | mem_hit | timeout);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d = ARB_GRANT;
                    grant_d = win;
                    wcnt_d  = '0;
                end
            end
            ARB_GRANT: begin
                if (done) begin
                    state_d = ARB_IDLE;
                    rr_d    = CH_W'(rr_next(int'(grant_q), NUM_CH));
                end else if (WAIT_LIMIT != 0) begin
                    wcnt_d  = wcnt_q + WC_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        mem_wen   = in_grant & g_wen;
        mem_ren   = in_grant & g_ren & ~g_wen;
        mem_addr  = (in_grant & g_act) ? g_addr  : '0;
        mem_store = (in_grant & g_act) ? g_store : '0;
        mem_width = (in_grant & g_act) ? g_width : '0;
        req_hit   = '0;
        if (in_grant && g_act && mem_hit) begin
            req_hit[grant_q] = 1'b1;
        end
    end

    assign req_load = nrst ? mem_load : '0;
    assign busy     = in_grant;
    assign grant    = grant_q;

endmodule
